// File: rtl/iccm_ctrl.sv
// ICCM controller: forwards requests to a 2048x32 synchronous SRAM and
// returns read data with a one-cycle valid. Optional macro ICCM_RAW_FWD_EN.
module iccm_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cntlr_rd,
  input  logic [ADDR_WIDTH-1:0] cntlr_raddr,
  output logic [DATA_WIDTH-1:0] cntlr_rd_data,
  output logic                  cntlr_rd_valid,
  input  logic                  cntlr_wr,
  input  logic [ADDR_WIDTH-1:0] cntlr_waddr,
  input  logic [DATA_WIDTH-1:0] cntlr_wr_data,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data
);

  logic                  rd_valid_reg;
  logic [DATA_WIDTH-1:0] hold_reg;
  logic [DATA_WIDTH-1:0] resp_data;

  // Requests go straight to the SRAM; reset blocks all traffic.
  assign mem_rd      = cntlr_rd & ~rst;
  assign mem_rd_addr = cntlr_raddr;
  assign mem_wr      = cntlr_wr & ~rst;
  assign mem_wr_addr = cntlr_waddr;
  assign mem_wr_data = cntlr_wr_data;

`ifdef ICCM_RAW_FWD_EN
  logic                  fwd_hit_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg;

  // Same-edge read/write to one address returns the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      fwd_hit_reg  <= cntlr_rd & cntlr_wr & (cntlr_raddr == cntlr_waddr);
      fwd_data_reg <= cntlr_wr_data;
    end
  end

  assign resp_data = fwd_hit_reg ? fwd_data_reg : mem_rd_data;
`else
  assign resp_data = mem_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      hold_reg     <= '0;
    end else begin
      rd_valid_reg <= cntlr_rd;
      if (rd_valid_reg) begin
        hold_reg <= resp_data;
      end
    end
  end

  assign cntlr_rd_valid = rd_valid_reg;
  assign cntlr_rd_data  = rd_valid_reg ? resp_data : hold_reg;

endmodule

// File: tb/tb_iccm_ctrl.sv
// Bench for iccm_ctrl: SRAM model plus a word-array reference of expected
// read results; directed scenarios followed by random traffic.
module tb_iccm_ctrl;

  logic        clk;
  logic        rst;
  logic        cntlr_rd;
  logic [10:0] cntlr_raddr;
  logic [31:0] cntlr_rd_data;
  logic        cntlr_rd_valid;
  logic        cntlr_wr;
  logic [10:0] cntlr_waddr;
  logic [31:0] cntlr_wr_data;
  logic        mem_rd;
  logic [10:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        mem_wr;
  logic [10:0] mem_wr_addr;
  logic [31:0] mem_wr_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] sram    [0:2047];
  logic [31:0] ref_mem [0:2047];
  logic [31:0] exp_data;
  logic        exp_valid;

`ifdef ICCM_RAW_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  iccm_ctrl #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .cntlr_rd(cntlr_rd), .cntlr_raddr(cntlr_raddr),
    .cntlr_rd_data(cntlr_rd_data), .cntlr_rd_valid(cntlr_rd_valid),
    .cntlr_wr(cntlr_wr), .cntlr_waddr(cntlr_waddr), .cntlr_wr_data(cntlr_wr_data),
    .mem_rd(mem_rd), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr(mem_wr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first synchronous SRAM
  always @(posedge clk) begin
    if (mem_rd) mem_rd_data <= sram[mem_rd_addr];
    if (mem_wr) sram[mem_wr_addr] <= mem_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; checks pass-through, then registered outputs.
  task automatic step(input logic r, input logic [10:0] ra, input logic w,
                      input logic [10:0] wa, input logic [31:0] wd, input logic rs);
    @(negedge clk);
    rst = rs; cntlr_rd = r; cntlr_raddr = ra;
    cntlr_wr = w; cntlr_waddr = wa; cntlr_wr_data = wd;
    #1;
    chk("mem_rd", {31'd0, mem_rd}, {31'd0, r & ~rs});
    chk("mem_wr", {31'd0, mem_wr}, {31'd0, w & ~rs});
    if (r) chk("mem_rd_addr", {21'd0, mem_rd_addr}, {21'd0, ra});
    if (w) begin
      chk("mem_wr_addr", {21'd0, mem_wr_addr}, {21'd0, wa});
      chk("mem_wr_data", mem_wr_data, wd);
    end
    exp_valid = r & ~rs;
    if (rs) exp_data = 32'd0;
    else if (r) exp_data = (FWD && w && ra == wa) ? wd : ref_mem[ra];
    if (w && !rs) ref_mem[wa] = wd;
    @(posedge clk);
    #1;
    chk("rd_valid", {31'd0, cntlr_rd_valid}, {31'd0, exp_valid});
    chk("rd_data", cntlr_rd_data, exp_data);
    $display("t=%0t rst=%0b rd=%0b ra=%0d wr=%0b wa=%0d wd=%h -> valid=%0b data=%h",
             $time, rs, r, ra, w, wa, wd, cntlr_rd_valid, cntlr_rd_data);
  endtask

  task automatic idle();
    step(1'b0, 11'd0, 1'b0, 11'd0, 32'd0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      sram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem_rd_data = 32'd0;
    exp_data = 32'd0;
    rst = 1'b1; cntlr_rd = 1'b0; cntlr_wr = 1'b0;
    cntlr_raddr = '0; cntlr_waddr = '0; cntlr_wr_data = '0;

    // Reset with requests asserted
    step(1'b1, 11'd3, 1'b1, 11'd3, 32'hFFFF_FFFF, 1'b1);
    step(1'b1, 11'd3, 1'b1, 11'd3, 32'hFFFF_FFFF, 1'b1);
    chk("reset_data", cntlr_rd_data, 32'd0);
    chk("reset_sram_untouched", sram[3], 32'd0);
    idle();
    chk("post_reset_valid", {31'd0, cntlr_rd_valid}, 32'd0);

    // Write then read
    step(1'b0, 11'd0, 1'b1, 11'd10, 32'hDEAD_BEEF, 1'b0);
    idle();
    step(1'b1, 11'd10, 1'b0, 11'd0, 32'd0, 1'b0);
    chk("wr_rd_data", cntlr_rd_data, 32'hDEAD_BEEF);
    idle();
    chk("hold_data", cntlr_rd_data, 32'hDEAD_BEEF);

    // Back-to-back reads including the top address
    step(1'b0, 11'd0, 1'b1, 11'd0, 32'h1111_1111, 1'b0);
    step(1'b0, 11'd0, 1'b1, 11'd2047, 32'h2222_2222, 1'b0);
    step(1'b1, 11'd0, 1'b0, 11'd0, 32'd0, 1'b0);
    chk("b2b_first", cntlr_rd_data, 32'h1111_1111);
    step(1'b1, 11'd2047, 1'b0, 11'd0, 32'd0, 1'b0);
    chk("b2b_top", cntlr_rd_data, 32'h2222_2222);
    idle();

    // Same-address collision
    step(1'b0, 11'd0, 1'b1, 11'd5, 32'hAAAA_0000, 1'b0);
    step(1'b1, 11'd5, 1'b1, 11'd5, 32'h5555_FFFF, 1'b0);
    chk("collision", cntlr_rd_data, FWD ? 32'h5555_FFFF : 32'hAAAA_0000);
    step(1'b1, 11'd5, 1'b0, 11'd0, 32'd0, 1'b0);
    chk("after_collision", cntlr_rd_data, 32'h5555_FFFF);

    // Different-address read and write in one cycle
    step(1'b1, 11'd10, 1'b1, 11'd6, 32'h0123_4567, 1'b0);
    chk("dual_rd", cntlr_rd_data, 32'hDEAD_BEEF);
    step(1'b1, 11'd6, 1'b0, 11'd0, 32'd0, 1'b0);
    chk("dual_wr", cntlr_rd_data, 32'h0123_4567);

    // Reset mid-read drops the response
    step(1'b1, 11'd6, 1'b0, 11'd0, 32'd0, 1'b1);
    idle();
    chk("rst_mid_valid", {31'd0, cntlr_rd_valid}, 32'd0);
    chk("rst_mid_data", cntlr_rd_data, 32'd0);

    // Pass-through of the write port
    step(1'b0, 11'd0, 1'b1, 11'h3FF, 32'h0BAD_F00D, 1'b0);
    chk("pass_sram", sram[11'h3FF], 32'h0BAD_F00D);

    // Random traffic on a small address window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      logic        r, w, rs;
      logic [10:0] ra, wa;
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 31) == 0);
      ra = ($urandom_range(0, 9) == 0) ? 11'd2047 : 11'($urandom_range(0, 7));
      wa = ($urandom_range(0, 9) == 0) ? 11'd2047 : 11'($urandom_range(0, 7));
      step(r, ra, w, wa, $urandom, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
